// File: rtl/game_datapath_core_if.sv
// Command/status bundle between the game controller FSM (master) and the datapath (slave).
interface game_datapath_core_if;
  logic r1;
  logic r2;
  logic e1;
  logic e2;
  logic e3;
  logic e4;
  logic sel;
  logic end_fpga;
  logic end_user;
  logic end_time;
  logic win;
  logic match;

  modport master (
    output r1, r2, e1, e2, e3, e4, sel,
    input  end_fpga, end_user, end_time, win, match
  );

  modport slave (
    input  r1, r2, e1, e2, e3, e4, sel,
    output end_fpga, end_user, end_time, win, match
  );
endinterface

// File: rtl/game_datapath_core.sv
// Datapath for the sequence-guessing game: code LFSR, 1 Hz round timers,
// guess capture from key[0], and round/point bookkeeping.
module game_datapath_core #(
  parameter int unsigned CLK_HZ    = 50000000,
  parameter int unsigned SHOW_SEC  = 2,
  parameter int unsigned ROUND_SEC = 10,
  parameter int unsigned N_ROUNDS  = 16
) (
  input  logic                      clock_50,
  input  logic                      reset,
  input  logic [3:0]                key,
  input  logic [7:0]                switch,
  game_datapath_core_if.slave       ctl,
  output logic [7:0]                disp,
  output logic [4:0]                round,
  output logic [3:0]                time_left,
  output logic [7:0]                points
);

  localparam int unsigned DIV_W  = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int unsigned SHOW_W = (SHOW_SEC > 0) ? $clog2(SHOW_SEC + 1) : 1;

  localparam logic [DIV_W-1:0]  DIV_LAST   = DIV_W'(CLK_HZ - 1);
  localparam logic [SHOW_W-1:0] SHOW_MAX   = SHOW_W'(SHOW_SEC);
  localparam logic [3:0]        ROUND_INIT = 4'(ROUND_SEC);
  localparam logic [4:0]        ROUND_WIN  = 5'(N_ROUNDS);
  localparam logic [7:0]        CODE_SEED  = 8'h01;
  localparam logic [7:0]        LFSR_TAPS  = 8'hB8;

  logic [DIV_W-1:0]  div;
  logic              tick;
  logic [SHOW_W-1:0] show_cnt;
  logic [7:0]        code;
  logic [7:0]        code_next;
  logic [7:0]        user_reg;
  logic [2:0]        key_sync;
  logic              press;
  logic              end_user_q;
  logic              match_q;
  logic              win;
  logic [8:0]        points_sum;
  logic              unused_keys;

  assign unused_keys = ^key[3:1];

  always_comb begin
    tick       = (div == DIV_LAST);
    // key_sync[1] is the synchronised level, key_sync[2] its previous value
    press      = key_sync[2] & ~key_sync[1];
    win        = (round == ROUND_WIN);
    points_sum = {1'b0, points} + {5'b0, time_left};
    code_next  = code[0] ? ((code >> 1) ^ LFSR_TAPS) : (code >> 1);
    disp       = ctl.sel ? user_reg : code;
  end

  assign ctl.end_fpga = (show_cnt == SHOW_MAX);
  assign ctl.end_time = (time_left == '0);
  assign ctl.end_user = end_user_q;
  assign ctl.match    = match_q;
  assign ctl.win      = win;

  // Synchroniser is restored to "released" on game clear so a held key
  // cannot leak a press across the abort.
  always_ff @(posedge clock_50) begin
    if (reset || ctl.r1) begin
      key_sync <= '1;
      match_q  <= 1'b0;
    end else begin
      key_sync <= {key_sync[1:0], key[0]};
      match_q  <= (user_reg == code);
    end
  end

  always_ff @(posedge clock_50) begin
    if (reset || ctl.r1) begin
      code       <= CODE_SEED;
      round      <= '0;
      points     <= '0;
      div        <= '0;
      show_cnt   <= '0;
      time_left  <= ROUND_INIT;
      user_reg   <= '0;
      end_user_q <= 1'b0;
    end else if (ctl.r2) begin
      div        <= '0;
      show_cnt   <= '0;
      time_left  <= ROUND_INIT;
      user_reg   <= '0;
      end_user_q <= 1'b0;
    end else begin
      div <= tick ? '0 : div + DIV_W'(1);

      if (tick && ctl.e1 && (show_cnt < SHOW_MAX))
        show_cnt <= show_cnt + SHOW_W'(1);

      if (tick && ctl.e2 && (time_left != '0))
        time_left <= time_left - 4'd1;

      end_user_q <= 1'b0;
      if (press && ctl.e3) begin
        user_reg   <= switch;
        end_user_q <= 1'b1;
      end

      if (ctl.e4 && !win) begin
        round  <= round + 5'd1;
        points <= points_sum[8] ? 8'hFF : points_sum[7:0];
        code   <= code_next;
      end
    end
  end

endmodule
